fetch_mem_arbiter: RTL and testbench
====================================

FETCH_MEM_ARBITER -- requirements
Module: fetch_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL be the word-address width of the shared RAM.
REQ-002 Parameter DATA_W, default 32, SHALL be the data width.
REQ-003 Parameter STARVE_MAX, default 3, SHALL be the maximum consecutive fetch denials.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 if_req  in  1  instruction-fetch request.
REQ-007 if_addr  in  ADDR_W  fetch word address (the PC).
REQ-008 if_gnt  out  1  fetch granted this cycle.
REQ-009 if_valid  out  1  if_rdata valid.
REQ-010 if_rdata  out  DATA_W  fetched instruction.
REQ-011 d_req  in  1  data-access request.
REQ-012 d_we  in  1  data write (1) or read (0).
REQ-013 d_addr  in  ADDR_W  data word address.
REQ-014 d_wdata  in  DATA_W  store data.
REQ-015 d_gnt  out  1  data access granted this cycle.
REQ-016 d_valid  out  1  load data valid, or store acknowledge.
REQ-017 d_rdata  out  DATA_W  load data.
REQ-018 ram_addr, ram_din, ram_we, ram_en  out  ADDR_W, DATA_W, 1, 1  shared synchronous single-port RAM drive.
REQ-019 ram_dout  in  DATA_W  RAM read data, available one cycle after the address.
REQ-020 stall  out  1  SHALL equal if_req & ~if_gnt (combinational).

Function
REQ-021 The block SHALL grant at most one requester per cycle; grants SHALL be combinational from the current requests and state.
REQ-022 Fixed priority: d_req SHALL win over if_req, except when starve_cnt == STARVE_MAX, in which case if_req SHALL win.
REQ-023 starve_cnt SHALL increment when if_req & ~if_gnt, saturate at STARVE_MAX, and clear when if_gnt or ~if_req.
REQ-024 In a granted cycle, ram_en=1 and ram_addr SHALL carry the winner's address. ram_we=d_we & d_gnt. ram_din=d_wdata.
REQ-025 With no grant, ram_en=0 and ram_we=0.
REQ-026 Response FSM states: RESP_NONE, RESP_IF, RESP_D. The next state SHALL be RESP_IF if if_gnt, RESP_D if d_gnt, and RESP_NONE otherwise.
REQ-027 In RESP_IF: if_valid=1 and if_rdata=ram_dout. In RESP_D: d_valid=1 and d_rdata=ram_dout; for stores, d_rdata is don't-care.
REQ-028 Latency from grant to valid SHALL be exactly 1 cycle. Back-to-back grants SHALL be sustained at one access per cycle.
REQ-029 rdata outputs SHALL be 0 when their valid is low.
REQ-030 A requester SHALL hold its request and address stable until granted. The arbiter SHALL NOT buffer requests.
REQ-031 if_addr and d_addr SHALL wrap modulo 2^ADDR_W with no range check.

Reset
REQ-032 While reset_n=0: FSM=RESP_NONE, starve_cnt=0, and all grant, valid, ram_en and ram_we outputs = 0.
REQ-033 Reset asserted mid-access SHALL drop the outstanding response; no valid SHALL follow reset release until a new grant.

Configuration
REQ-034 Macro ARB_ROUND_ROBIN_EN: when defined, REQ-022 and REQ-023 are replaced by round-robin. On simultaneous requests, the requester not granted last SHALL win. starve_cnt SHALL NOT be built.
REQ-035 Without ARB_ROUND_ROBIN_EN, fixed priority with the starvation guard SHALL apply.

Structure
REQ-036 Shared package mips_pkg SHALL hold: ADDR_W and DATA_W defaults, the response-state enumeration, and the STARVE_MAX default.
REQ-037 One sub-module, arb_starve_cnt (a saturating counter), is natural. All other logic SHALL be flat.

Verification
REQ-038 Reset: hold reset_n=0 with both requests high -> all grants, valids and ram_en stay 0; valids stay 0 for 1 cycle after release.
REQ-039 Fetch only: if_req=1, if_addr=5, RAM[5]=32'h2002000A -> if_gnt in cycle N; if_valid with if_rdata=32'h2002000A in N+1.
REQ-040 Contention (fixed): if_req=d_req=1 continuously -> d_gnt for 3 cycles, then if_gnt in the 4th, then the pattern repeats; stall=1 exactly on the denied cycles.
REQ-041 Store then load: d_we=1, d_addr=9, d_wdata=32'hDEADBEEF, then a read of address 9 -> d_valid ack, then d_rdata=32'hDEADBEEF one cycle after the second grant.
REQ-042 Round-robin build: continuous contention -> grants alternate D, IF, D, IF; starve_cnt absent.
REQ-043 Reset mid-access: assert reset_n=0 in the cycle after if_gnt -> no if_valid appears.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared defaults and response-state type for fetch_mem_arbiter
package mips_pkg;

    localparam int DEF_ADDR_W     = 4;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 3;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_D    = 2'd2
    } resp_state_e;

endpackage

// File: rtl/fetch_mem_arbiter_if.sv
// rtl/fetch_mem_arbiter_if.sv - fetch/data request ports and shared RAM drive
interface fetch_mem_arbiter_if #(
    parameter int ADDR_W = mips_pkg::DEF_ADDR_W,
    parameter int DATA_W = mips_pkg::DEF_DATA_W
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_we;
    logic              ram_en;
    logic [DATA_W-1:0] ram_dout;
    logic              stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_dout,
        output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
        output ram_addr, ram_din, ram_we, ram_en, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_dout,
        input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
        input  ram_addr, ram_din, ram_we, ram_en, stall
    );
endinterface

// File: rtl/arb_starve_cnt.sv
// rtl/arb_starve_cnt.sv - saturating count of consecutive fetch denials
module arb_starve_cnt #(
    parameter int MAX = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    output logic full
);
    localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        full  = (cnt_q == CW'(MAX));
        cnt_d = '0;
        if (inc) begin
            cnt_d = full ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/fetch_mem_arbiter.sv
// rtl/fetch_mem_arbiter.sv - fetch/data arbiter for one single-port RAM
// ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority with starvation guard.
module fetch_mem_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                clk,
    input  logic                reset_n,
    fetch_mem_arbiter_if.slave  bus
);
    resp_state_e       state_q;
    resp_state_e       state_d;
    logic              if_wins;
    logic              if_gnt;
    logic              d_gnt;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] rdata_zero;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q;
    logic last_d_d;

    // On contention the side that did not win most recently goes next.
    always_comb begin
        if_wins  = bus.if_req & (~bus.d_req | last_d_q);
        last_d_d = last_d_q;
        if (d_gnt) begin
            last_d_d = 1'b1;
        end else if (if_gnt) begin
            last_d_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    logic starve_full;

    arb_starve_cnt #(.MAX(STARVE_MAX)) u_starve_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (bus.if_req & ~if_gnt),
        .full    (starve_full)
    );

    always_comb begin
        if_wins = bus.if_req & (~bus.d_req | starve_full);
    end
`endif

    always_comb begin
        if_gnt     = reset_n & if_wins;
        d_gnt      = reset_n & bus.d_req & ~if_wins;
        addr_sel   = d_gnt ? bus.d_addr : bus.if_addr;
        rdata_zero = '0;
        state_d    = RESP_NONE;
        if (if_gnt) begin
            state_d = RESP_IF;
        end else if (d_gnt) begin
            state_d = RESP_D;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RESP_NONE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.if_gnt   = if_gnt;
    assign bus.d_gnt    = d_gnt;
    assign bus.stall    = bus.if_req & ~if_gnt;
    assign bus.ram_en   = if_gnt | d_gnt;
    assign bus.ram_we   = bus.d_we & d_gnt;
    assign bus.ram_addr = addr_sel;
    assign bus.ram_din  = bus.d_wdata;
    assign bus.if_valid = (state_q == RESP_IF);
    assign bus.d_valid  = (state_q == RESP_D);
    assign bus.if_rdata = (state_q == RESP_IF) ? bus.ram_dout : rdata_zero;
    assign bus.d_rdata  = (state_q == RESP_D) ? bus.ram_dout : rdata_zero;
endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// tb/tb_fetch_mem_arbiter.sv - scoreboard bench for fetch_mem_arbiter
module tb_fetch_mem_arbiter;

    typedef struct {
        bit          is_if;
        bit          is_store;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    exp_t q[$];
    logic [31:0] ram[16];
    logic [31:0] ref_mem[16];

    fetch_mem_arbiter_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    fetch_mem_arbiter #(.ADDR_W(4), .DATA_W(32), .STARVE_MAX(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM, read-first.
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_din;
            bus.ram_dout <= ram[bus.ram_addr];
        end
    end

    // Response scoreboard: an entry pushed in grant cycle N must be consumed in N+1.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_if;
        bit   exp_d;
        exp_if = 1'b0;
        exp_d  = 1'b0;
        e      = '{is_if: 1'b0, is_store: 1'b0, data: 32'h0};
        if (q.size() > 0) begin
            e = q.pop_front();
            exp_if = e.is_if;
            exp_d  = ~e.is_if;
        end
        checks++;
        if (bus.if_valid !== exp_if) begin
            errors++;
            $display("FAIL if_valid: got %b expected %b at %0t", bus.if_valid, exp_if, $time);
        end
        checks++;
        if (bus.d_valid !== exp_d) begin
            errors++;
            $display("FAIL d_valid: got %b expected %b at %0t", bus.d_valid, exp_d, $time);
        end
        checks++;
        if (bus.if_rdata !== (exp_if ? e.data : 32'h0)) begin
            errors++;
            $display("FAIL if_rdata: got %h expected %h at %0t", bus.if_rdata, exp_if ? e.data : 32'h0, $time);
        end
        if (!(exp_d && e.is_store)) begin
            checks++;
            if (bus.d_rdata !== (exp_d ? e.data : 32'h0)) begin
                errors++;
                $display("FAIL d_rdata: got %h expected %h at %0t", bus.d_rdata, exp_d ? e.data : 32'h0, $time);
            end
        end
    end

    task automatic drive(input bit ir, input logic [3:0] ia, input bit dr, input bit dw,
                         input logic [3:0] da, input logic [31:0] dd);
        bus.if_req  = ir;
        bus.if_addr = ia;
        bus.d_req   = dr;
        bus.d_we    = dw;
        bus.d_addr  = da;
        bus.d_wdata = dd;
    endtask

    task automatic push(input bit is_if, input bit is_store, input logic [31:0] data);
        #1;
        q.push_back('{is_if: is_if, is_store: is_store, data: data});
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        drive(1'b1, 4'd1, 1'b1, 1'b0, 4'd3, 32'h0);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({bus.if_gnt, bus.d_gnt, bus.ram_en, bus.ram_we, bus.if_valid, bus.d_valid} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs: got %b expected 000000",
                         {bus.if_gnt, bus.d_gnt, bus.ram_en, bus.ram_we, bus.if_valid, bus.d_valid});
            end
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.d_gnt, bus.if_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release_gnt: got d/if %b expected 10", {bus.d_gnt, bus.if_gnt});
        end
        push(1'b0, 1'b0, ref_mem[3]);
        @(posedge clk); #1;
        drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
    endtask

    task automatic test_fetch_only;
        @(posedge clk); #1;
        drive(1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        checks++;
        if ({bus.if_gnt, bus.d_gnt, bus.stall, bus.ram_en, bus.ram_we} !== 5'b10010 || bus.ram_addr !== 4'd5) begin
            errors++;
            $display("FAIL fetch_grant: got gnt/d/stall/en/we %b addr %0d expected 10010 addr 5",
                     {bus.if_gnt, bus.d_gnt, bus.stall, bus.ram_en, bus.ram_we}, bus.ram_addr);
        end
        push(1'b1, 1'b0, 32'h2002000A);
        @(posedge clk); #1;
        drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        checks++;
        if ({bus.if_gnt, bus.d_gnt, bus.ram_en, bus.ram_we} !== 4'b0) begin
            errors++;
            $display("FAIL idle_no_grant: got %b expected 0000", {bus.if_gnt, bus.d_gnt, bus.ram_en, bus.ram_we});
        end
    endtask

    task automatic test_contention;
        bit exp_if;
        @(posedge clk); #1;
        drive(1'b1, 4'd7, 1'b1, 1'b0, 4'd2, 32'h0);
        for (int i = 0; i < 8; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_if = (i % 2 == 1);
`else
            exp_if = (i % 4 == 3);
`endif
            @(negedge clk);
            checks++;
            if ({bus.if_gnt, bus.d_gnt, bus.stall} !== {exp_if, ~exp_if, ~exp_if}) begin
                errors++;
                $display("FAIL contention_%0d: got if/d/stall %b expected %b", i,
                         {bus.if_gnt, bus.d_gnt, bus.stall}, {exp_if, ~exp_if, ~exp_if});
            end
            push(exp_if, 1'b0, exp_if ? ref_mem[7] : ref_mem[2]);
            @(posedge clk); #1;
        end
        drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
    endtask

    task automatic test_store_load;
        @(posedge clk); #1;
        drive(1'b0, 4'd0, 1'b1, 1'b1, 4'd9, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if ({bus.d_gnt, bus.ram_we, bus.ram_en} !== 3'b111 || bus.ram_addr !== 4'd9 || bus.ram_din !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_drive: got gnt/we/en %b addr %0d din %h expected 111 9 deadbeef",
                     {bus.d_gnt, bus.ram_we, bus.ram_en}, bus.ram_addr, bus.ram_din);
        end
        ref_mem[9] = 32'hDEADBEEF;
        push(1'b0, 1'b1, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 4'd0, 1'b1, 1'b0, 4'd9, 32'h0);
        @(negedge clk);
        checks++;
        if ({bus.d_gnt, bus.ram_we} !== 2'b10) begin
            errors++;
            $display("FAIL load_drive: got gnt/we %b expected 10", {bus.d_gnt, bus.ram_we});
        end
        push(1'b0, 1'b0, ref_mem[9]);
        @(posedge clk); #1;
        drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i % 2 == 0) drive(1'b1, 4'(15 - i), 1'b0, 1'b0, 4'd0, 32'h0);
            else            drive(1'b0, 4'd0, 1'b1, 1'b0, 4'(i), 32'h0);
            @(negedge clk);
            checks++;
            if (bus.ram_en !== 1'b1 || bus.ram_addr !== ((i % 2 == 0) ? 4'(15 - i) : 4'(i))) begin
                errors++;
                $display("FAIL b2b_%0d: got en %b addr %0d", i, bus.ram_en, bus.ram_addr);
            end
            push(i % 2 == 0, 1'b0, (i % 2 == 0) ? ref_mem[15 - i] : ref_mem[i]);
        end
        @(posedge clk); #1;
        drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        drive(1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.if_gnt !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_gnt: got %b expected 1", bus.if_gnt);
        end
        @(posedge clk); #1;
        reset_n = 1'b0;
        q.delete();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.if_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_valid: got %b expected 0", bus.if_valid);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) begin
            ram[i]     = 32'h1000_0000 + 32'(i) * 32'h111;
            ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h111;
        end
        ram[5]     = 32'h2002000A;
        ref_mem[5] = 32'h2002000A;
        bus.ram_dout = 32'h0;
        test_reset();
        test_fetch_only();
        test_contention();
        test_store_load();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
